stfq_rank_computer: RTL and testbench

// - Upstream enqueue stage of the PIFO: assigns Start-Time Fair Queueing ranks to arriving packets.
// - Keeps per-flow last finish tags and a global virtual time.
// - Emits one registered push (rank, value, one-hot flow) per accepted packet into the PIFO enqueue port.
// - Virtual time advances from the rank of each packet the downstream scheduler dequeues.

---
 rtl/pifo_pkg.sv | 22 ++
 rtl/flow_onehot_enc.sv | 26 ++
 rtl/stfq_rank_computer.sv | 130 +++++++++++++
 tb/tb_stfq_rank_computer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared PIFO enqueue-side types: rank type, its ceiling and saturating helpers.
package pifo_pkg;

  localparam int unsigned RANK_W = 32;

  typedef logic [RANK_W-1:0] rank_t;

  localparam rank_t RANK_MAX = '1;

  // Add two ranks, clamping at RANK_MAX instead of wrapping.
  function automatic rank_t sat_add(input rank_t a, input rank_t b);
    logic [RANK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[RANK_W] ? RANK_MAX : sum[RANK_W-1:0];
  endfunction

  // Larger of two ranks.
  function automatic rank_t rank_max(input rank_t a, input rank_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flow_onehot_enc.sv
// One-hot flow id to binary index, with a strict one-hot qualifier.
module flow_onehot_enc #(
  parameter int unsigned N     = 10,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // OR together the indices of set bits; exact only when valid_o is high.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IDX_W'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - N'(1))) == '0);
  end

endmodule

// File: rtl/stfq_rank_computer.sv
// Start-Time Fair Queueing rank assignment for the PIFO enqueue port.
// Keeps a per-flow finish tag, a per-flow weight shift and a global virtual
// time; each accepted packet is pushed one cycle later with rank = start tag.
module stfq_rank_computer
  import pifo_pkg::*;
#(
  parameter int unsigned FLOWS   = 10,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_value,
  input  logic [FLOWS-1:0]         in_flow,
  input  logic [LEN_W-1:0]         in_len,
  input  logic                     cfg_we,
  input  logic [$clog2(FLOWS)-1:0] cfg_flow,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     vt_valid,
  input  logic [31:0]              vt_rank,
  output logic                     push,
  output logic [31:0]              push_rank,
  output logic [31:0]              push_value,
  output logic [FLOWS-1:0]         push_flow,
  output logic                     err_flow
);

  localparam int unsigned IDX_W = $clog2(FLOWS);

  // Architectural state
  rank_t              vt_q, vt_d;
  rank_t              finish_q [FLOWS];
  rank_t              finish_d [FLOWS];
  logic [SHIFT_W-1:0] shift_q  [FLOWS];
  logic [SHIFT_W-1:0] shift_d  [FLOWS];

  // Output register
  logic               push_q;
  rank_t              push_rank_q;
  logic [31:0]        push_value_q;
  logic [FLOWS-1:0]   push_flow_q;
  logic               err_flow_q, err_flow_d;

  // Datapath
  logic [IDX_W-1:0]   in_idx;
  logic               in_onehot;
  logic               accept_c;
  logic               reject_c;
  rank_t              fin_sel_c;
  logic [SHIFT_W-1:0] shift_sel_c;
  rank_t              start_c;
  rank_t              cost_c;

  flow_onehot_enc #(
    .N     (FLOWS),
    .IDX_W (IDX_W)
  ) u_flow_enc (
    .onehot_i (in_flow),
    .idx_o    (in_idx),
    .valid_o  (in_onehot)
  );

  // Start tag and cost for the arriving packet, all from pre-edge state.
  always_comb begin
    accept_c    = in_valid && in_onehot;
    reject_c    = in_valid && !in_onehot;
    fin_sel_c   = finish_q[in_idx];
    shift_sel_c = shift_q[in_idx];
    start_c     = rank_max(vt_q, fin_sel_c);
    cost_c      = RANK_W'(in_len) << shift_sel_c;
  end

  // Next-state for virtual time, finish tags, weights and the error flag.
  always_comb begin
    vt_d       = vt_q;
    finish_d   = finish_q;
    shift_d    = shift_q;
    err_flow_d = err_flow_q;

    if (vt_valid) begin
      vt_d = rank_max(vt_q, vt_rank);
    end

    if (accept_c) begin
      finish_d[in_idx] = sat_add(start_c, cost_c);
    end

    // Out-of-range flow indices are dropped silently.
    if (cfg_we && (cfg_flow < IDX_W'(FLOWS))) begin
      shift_d[cfg_flow] = cfg_shift;
    end

    if (reject_c) begin
      err_flow_d = 1'b1;
    end
  end

  // State and output registers; reset also drops any push in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vt_q         <= '0;
      err_flow_q   <= 1'b0;
      push_q       <= 1'b0;
      push_rank_q  <= '0;
      push_value_q <= '0;
      push_flow_q  <= '0;
      for (int unsigned i = 0; i < FLOWS; i++) begin
        finish_q[i] <= '0;
        shift_q[i]  <= '0;
      end
    end else begin
      vt_q         <= vt_d;
      err_flow_q   <= err_flow_d;
      push_q       <= accept_c;
      push_rank_q  <= start_c;
      push_value_q <= in_value;
      push_flow_q  <= in_flow;
      finish_q     <= finish_d;
      shift_q      <= shift_d;
    end
  end

  assign push       = push_q;
  assign push_rank  = push_rank_q;
  assign push_value = push_value_q;
  assign push_flow  = push_flow_q;
  assign err_flow   = err_flow_q;

endmodule

// File: tb/tb_stfq_rank_computer.sv
// Directed scoreboard bench for stfq_rank_computer.
module tb_stfq_rank_computer;

  localparam int unsigned FLOWS   = 10;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned SHIFT_W = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [31:0]        in_value;
  logic [FLOWS-1:0]   in_flow;
  logic [LEN_W-1:0]   in_len;
  logic               cfg_we;
  logic [3:0]         cfg_flow;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               vt_valid;
  logic [31:0]        vt_rank;
  logic               push;
  logic [31:0]        push_rank;
  logic [31:0]        push_value;
  logic [FLOWS-1:0]   push_flow;
  logic               err_flow;

  stfq_rank_computer #(
    .FLOWS   (FLOWS),
    .LEN_W   (LEN_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .in_flow    (in_flow),
    .in_len     (in_len),
    .cfg_we     (cfg_we),
    .cfg_flow   (cfg_flow),
    .cfg_shift  (cfg_shift),
    .vt_valid   (vt_valid),
    .vt_rank    (vt_rank),
    .push       (push),
    .push_rank  (push_rank),
    .push_value (push_value),
    .push_flow  (push_flow),
    .err_flow   (err_flow)
  );

  typedef struct {
    logic [31:0]      rank;
    logic [31:0]      value;
    logic [FLOWS-1:0] flow;
    int               cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] seq   = 32'hC000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every push must match the head of the scoreboard in payload and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (push === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_push cyc=%0d rank=%h value=%h flow=%b", cyc, push_rank, push_value, push_flow);
      end else begin
        e = exp_q.pop_front();
        if (push_rank !== e.rank || push_value !== e.value || push_flow !== e.flow || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL push_payload got rank=%h value=%h flow=%b cyc=%0d expected rank=%h value=%h flow=%b cyc=%0d",
                   push_rank, push_value, push_flow, cyc, e.rank, e.value, e.flow, e.cyc);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      n_cmp++;
      n_bad++;
      e = exp_q.pop_front();
      $display("FAIL missing_push cyc=%0d push=%b expected rank=%h value=%h", cyc, push, e.rank, e.value);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    in_valid  = 1'b0;
    in_value  = '0;
    in_flow   = '0;
    in_len    = '0;
    cfg_we    = 1'b0;
    cfg_flow  = '0;
    cfg_shift = '0;
    vt_valid  = 1'b0;
    vt_rank   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Present a packet this cycle; optionally record the push it must produce.
  task automatic pkt(input logic [FLOWS-1:0] flow, input logic [15:0] len,
                     input logic [31:0] rank, input bit expect_push);
    exp_t e;
    seq      = seq + 32'd1;
    in_valid = 1'b1;
    in_flow  = flow;
    in_len   = len;
    in_value = seq;
    if (expect_push) begin
      e.rank  = rank;
      e.value = seq;
      e.flow  = flow;
      e.cyc   = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic cfg(input logic [3:0] f, input logic [SHIFT_W-1:0] sh);
    cfg_we    = 1'b1;
    cfg_flow  = f;
    cfg_shift = sh;
  endtask

  task automatic vt(input logic [31:0] r);
    vt_valid = 1'b1;
    vt_rank  = r;
  endtask

  localparam logic [FLOWS-1:0] F0 = 10'b00_0000_0001;
  localparam logic [FLOWS-1:0] F1 = 10'b00_0000_0010;
  localparam logic [FLOWS-1:0] F2 = 10'b00_0000_0100;
  localparam logic [FLOWS-1:0] F3 = 10'b00_0000_1000;
  localparam logic [FLOWS-1:0] F4 = 10'b00_0001_0000;

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_push", 32'(push), 32'd0);
    check("reset_rank", push_rank, 32'd0);
    check("reset_value", push_value, 32'd0);
    check("reset_flow", 32'(push_flow), 32'd0);
    check("reset_err", 32'(err_flow), 32'd0);
    rst = 1'b0;
    step();

    // First packet, then an idle cycle, then a back-to-back burst on flow 0.
    pkt(F0, 16'd100, 32'd0, 1'b1);   step();
    step();
    pkt(F0, 16'd100, 32'd100, 1'b1); step();
    pkt(F0, 16'd100, 32'd200, 1'b1); step();
    pkt(F0, 16'd100, 32'd300, 1'b1); step();

    // Packet sees the pre-edge vt; the next one sees the new vt.
    vt(32'd500); pkt(F2, 16'd7, 32'd0, 1'b1); step();
    pkt(F2, 16'd1, 32'd500, 1'b1); step();

    // Weight shift 1 on flow 1: cost doubles.
    cfg(4'd1, 4'd1); step();
    vt(32'd600); step();
    pkt(F1, 16'd10, 32'd600, 1'b1); step();
    pkt(F1, 16'd5, 32'd620, 1'b1);  step();

    // vt never decreases.
    vt(32'd100); step();
    pkt(F4, 16'd3, 32'd600, 1'b1); step();

    // Weight write on the packet's own flow in the same cycle uses the old shift.
    cfg(4'd1, 4'd3); pkt(F1, 16'd4, 32'd630, 1'b1); step();
    pkt(F1, 16'd4, 32'd638, 1'b1); step();
    cfg(4'd12, 4'd7); step();

    // Non-one-hot flow ids are rejected and flagged.
    pkt(F1 | F2, 16'd100, 32'd0, 1'b0); step();
    check("err_after_multihot", 32'(err_flow), 32'd1);
    pkt('0, 16'd100, 32'd0, 1'b0); step();
    pkt(F1, 16'd0, 32'd670, 1'b1); step();
    check("err_sticky", 32'(err_flow), 32'd1);

    // Finish tag saturates instead of wrapping.
    vt(32'hFFFF_FF00); step();
    pkt(F3, 16'd0, 32'hFFFF_FF00, 1'b1);     step();
    pkt(F3, 16'h0200, 32'hFFFF_FF00, 1'b1);  step();
    pkt(F3, 16'd1, 32'hFFFF_FFFF, 1'b1);     step();
    pkt(F3, 16'd1, 32'hFFFF_FFFF, 1'b1);     step();
    check("err_still_set", 32'(err_flow), 32'd1);

    // Reset mid-burst: the packet accepted at the reset edge never pushes.
    pkt(F0, 16'd5, 32'hFFFF_FF00, 1'b1); step();
    rst = 1'b1;
    pkt(F0, 16'd5, 32'd0, 1'b0); step();
    rst = 1'b0;
    check("midreset_push_dropped", 32'(push), 32'd0);
    check("midreset_err_cleared", 32'(err_flow), 32'd0);
    pkt(F0, 16'd50, 32'd0, 1'b1);  step();
    pkt(F0, 16'd50, 32'd50, 1'b1); step();
    pkt(F3, 16'd1, 32'd0, 1'b1);   step();
    pkt(F1, 16'd10, 32'd0, 1'b1);  step();
    pkt(F1, 16'd1, 32'd10, 1'b1);  step();

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_push_idle", 32'(push), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
